// File: rtl/line_memory_pkg.sv
// Line geometry and FSM states shared by the line memory model and the data cache.
package line_memory_pkg;

  localparam int LINE_W   = 256;
  localparam int DEPTH    = 512;
  localparam int IDX_W    = 9;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 4;

  localparam logic [CNT_W-1:0] ACK_COUNT = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/line_memory.sv
// Off-chip main-memory model: 512 x 256-bit lines, one whole-line read or write
// per request, completing with a single-cycle ack after a fixed latency.
module line_memory
  import line_memory_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  logic [LINE_W-1:0] memory [DEPTH];

  state_e            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx;

  // Byte offset dropped; addresses beyond 16 KB wrap onto the same lines.
  assign idx    = IDX_W'(addr_i >> OFFSET_W);
  assign data_o = memory[idx];
  assign ack_o  = (state == WAIT) && (cnt == ACK_COUNT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults come first so every path assigns every output and no latch
  // is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    unique case (state)
      IDLE: begin
        if (enable_i) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt == ACK_COUNT) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the storage array deliberately has no reset, so contents survive
  // rst_i and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) begin
      memory[idx] <= data_i;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed test-plan steps plus random
// requests, checked against an array-based reference of the memory contents.
module tb_line_memory;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] model_mem [512];

  line_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] addr);
    int unsigned a;
    a = addr;
    return int'((a / 32) % 512);
  endfunction

  function automatic logic [255:0] word_pattern(input logic [15:0] step);
    logic [255:0] v;
    for (int w = 0; w < 16; w++) v[w*16 +: 16] = 16'(w) * step;
    return v;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete request, entered and left on a falling edge with the FSM idle.
  // After rising edge Ek the ack must be high only for k == 8; a write lands at E9.
  task automatic req(input string tag, input logic [31:0] addr, input logic [255:0] wdata,
                     input logic wr, input logic early_drop);
    int idx;
    idx      = line_of(addr);
    addr_i   = addr;
    data_i   = wdata;
    write_i  = wr;
    enable_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (early_drop && k == 0) enable_i = 1'b0;
      if (k == 9 && wr) model_mem[idx] = wdata;
      check($sformatf("%s ack E%0d", tag, k), 256'(ack_o), 256'(k == 8));
      if (k == 8) begin
        if (!wr) check({tag, " rdata"}, data_o, model_mem[idx]);
        check({tag, " mem before commit"}, dut.memory[idx], model_mem[idx]);
        enable_i = 1'b0;
      end
      if (k == 9) check({tag, " mem after"}, dut.memory[idx], model_mem[idx]);
    end
  endtask

  initial begin
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;

    for (int i = 0; i < 512; i++) model_mem[i] = rand_line();
    model_mem[0]  = word_pattern(16'h1111);
    model_mem[1]  = rand_line();
    model_mem[2]  = {16{16'hECFA}};
    model_mem[17] = word_pattern(16'h0110);
    for (int i = 0; i < 512; i++) dut.memory[i] = model_mem[i];

    repeat (2) begin
      @(negedge clk_i);
      check("reset ack", 256'(ack_o), 256'(0));
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check("idle ack", 256'(ack_o), 256'(0));

    req("read0", 32'h0, '0, 1'b0, 1'b0);
    req("write400", 32'h400, {32{8'hA5}}, 1'b1, 1'b0);
    check("write400 value", model_mem[32], {32{8'hA5}});
    req("read400", 32'h400, '0, 1'b0, 1'b0);
    req("read21f", 32'h21F, '0, 1'b0, 1'b0);
    req("alias4000", 32'h4000, '0, 1'b0, 1'b0);
    check("alias data", data_o, word_pattern(16'h1111));

    // Back-to-back: enable held high, the second request starts at E10.
    addr_i   = 32'h20;
    write_i  = 1'b0;
    enable_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check($sformatf("b2b ack E%0d", k), 256'(ack_o), 256'(k == 8 || k == 18));
      if (k == 8)  check("b2b rdata1", data_o, model_mem[1]);
      if (k == 9)  addr_i = 32'h40;
      if (k == 18) begin
        check("b2b rdata2", data_o, {16{16'hECFA}});
        enable_i = 1'b0;
      end
    end

    // Reset during a write: no ack and the target line keeps its contents.
    addr_i   = 32'h220;
    data_i   = {32{8'h3C}};
    write_i  = 1'b1;
    enable_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rst_i    = 1'b0;
    enable_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check($sformatf("rst mid ack %0d", k), 256'(ack_o), 256'(0));
      if (k == 2) rst_i = 1'b1;
    end
    check("rst mid mem17", dut.memory[17], word_pattern(16'h0110));
    req("after rst read", 32'h220, '0, 1'b0, 1'b0);

    req("early drop", 32'h60, rand_line(), 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      check($sformatf("no second req %0d", k), 256'(ack_o), 256'(0));
    end

    for (int n = 0; n < 30; n++) begin
      req($sformatf("rand%0d", n), $urandom, rand_line(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0));
    end

    for (int n = 0; n < 16; n++) begin
      int i;
      i = $urandom_range(0, 511);
      check($sformatf("final mem[%0d]", i), dut.memory[i], model_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
